// File: rtl/fp_compare_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fp_cmp_pkg
// Shared definitions for the pipelined FloPoCo comparator/selector.
//
// Contents:
//   op_e        - operation mode codes (OP_GT .. OP_MAX)
//   exn_e       - FloPoCo exception class codes (EXN_ZERO .. EXN_NAN)
//   cls_t       - decoded operand class bundle registered in stage 1
//   op_width    - operand width W = WE+WF+3
//   exn_lsb     - bit index of the low exception bit
//   sign_idx    - bit index of the sign bit
//   mag_width   - width of the {exp,frac} magnitude field
//   canon_nan   - canonical NaN (exn=11, every other bit 0), MAX_W wide
//   rank_of     - total-order rank of a non-NaN operand class
// -----------------------------------------------------------------------------
package fp_cmp_pkg;

    typedef enum logic [2:0] {
        OP_GT  = 3'b000,
        OP_GE  = 3'b001,
        OP_LT  = 3'b010,
        OP_LE  = 3'b011,
        OP_EQ  = 3'b100,
        OP_NE  = 3'b101,
        OP_MIN = 3'b110,
        OP_MAX = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        EXN_ZERO = 2'b00,
        EXN_NORM = 2'b01,
        EXN_INF  = 2'b10,
        EXN_NAN  = 2'b11
    } exn_e;

    typedef struct packed {
        logic is_zero;
        logic is_norm;
        logic is_inf;
        logic is_nan;
        logic sign;
    } cls_t;

    // Upper bound on operand width for width-generic constant helpers.
    localparam int MAX_W = 128;

    function automatic int op_width(input int we, input int wf);
        return we + wf + 3;
    endfunction

    function automatic int exn_lsb(input int we, input int wf);
        return we + wf + 1;
    endfunction

    function automatic int sign_idx(input int we, input int wf);
        return we + wf;
    endfunction

    function automatic int mag_width(input int we, input int wf);
        return we + wf;
    endfunction

    // Callers truncate the result to their own operand width.
    function automatic logic [MAX_W-1:0] canon_nan(input int we, input int wf);
        return MAX_W'(EXN_NAN) << exn_lsb(we, wf);
    endfunction

    // -inf=0, -normal=1, zero (either sign)=2, +normal=3, +inf=4.
    // Only meaningful for non-NaN operands; NaN is handled separately.
    function automatic logic [2:0] rank_of(input cls_t c);
        logic [2:0] r;
        r = c.sign ? 3'd1 : 3'd3;
        if (c.is_zero) begin
            r = 3'd2;
        end else if (c.is_inf) begin
            r = c.sign ? 3'd0 : 3'd4;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_compare_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_compare_pipe_if
// Operation/result handshake bundle for fp_compare_pipe.
//
// Signals:
//   in_valid/in_ready     - operation handshake (upstream -> block)
//   in_op                 - 3-bit mode code (fp_cmp_pkg::op_e)
//   in_a/in_b             - FloPoCo operands, W = WE+WF+3 bits
//   in_tag                - opaque tag, returned with the result
//   out_valid/out_ready   - result handshake (block -> downstream)
//   out_flag              - predicate result; for MIN/MAX 1 = B selected
//   out_val               - selected operand for MIN/MAX, 0 otherwise
//   out_unord             - at least one operand was NaN
//   out_tag               - tag of the result
// Modports:
//   master - the side that issues operations and consumes results
//   slave  - the comparator itself
// -----------------------------------------------------------------------------
interface fp_compare_pipe_if #(
    parameter int WE    = 11,
    parameter int WF    = 22,
    parameter int TAG_W = 4
);
    localparam int W = WE + WF + 3;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic             out_flag;
    logic [W-1:0]     out_val;
    logic             out_unord;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_flag, out_val, out_unord, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_flag, out_val, out_unord, out_tag
    );

endinterface

// File: rtl/fp_compare_pipe_classify.sv
// -----------------------------------------------------------------------------
// fp_classify
// Combinational decode of one FloPoCo operand.
//
// Ports:
//   x        in   W      operand ([W-1:W-2] exn, [W-3] sign, rest {exp,frac})
//   is_zero  out  1      exn == 00
//   is_norm  out  1      exn == 01
//   is_inf   out  1      exn == 10
//   is_nan   out  1      exn == 11
//   sign     out  1      sign bit (meaningful for normals and infinities)
//   mag      out  WE+WF  unsigned {exp,frac}; orders normals of equal sign
// -----------------------------------------------------------------------------
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 22
) (
    input  logic [WE+WF+2:0] x,
    output logic             is_zero,
    output logic             is_norm,
    output logic             is_inf,
    output logic             is_nan,
    output logic             sign,
    output logic [WE+WF-1:0] mag
);

    localparam int EXN_LO = exn_lsb(WE, WF);
    localparam int SIGN_I = sign_idx(WE, WF);
    localparam int MAG_W  = mag_width(WE, WF);

    logic [1:0] exn;

    assign exn     = x[EXN_LO+1:EXN_LO];
    assign is_zero = (exn == EXN_ZERO);
    assign is_norm = (exn == EXN_NORM);
    assign is_inf  = (exn == EXN_INF);
    assign is_nan  = (exn == EXN_NAN);
    assign sign    = x[SIGN_I];
    assign mag     = x[MAG_W-1:0];

endmodule

// File: rtl/fp_compare_pipe.sv
// -----------------------------------------------------------------------------
// fp_compare_pipe
// Two-stage pipelined FloPoCo comparator/selector with valid/ready handshake
// and tag passthrough. Compares operands by exception-class rank plus an
// unsigned {exp,frac} magnitude compare -- no subtractor.
//
// Ports:
//   clk  in  1   clock, rising edge
//   rst  in  1   synchronous active-high reset
//   bus  slave   fp_compare_pipe_if (operation in / result out)
//
// Stage 1 holds operands, op, tag, both operand classes and the magnitude
// lt/eq. Stage 2 holds the final flag, selected value, unordered bit and tag.
// Each stage loads when empty or when its current content leaves in the
// same cycle, so bubbles collapse and throughput is one op per cycle.
// -----------------------------------------------------------------------------
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE    = 11,
    parameter int WF    = 22,
    parameter int TAG_W = 4
) (
    input logic               clk,
    input logic               rst,
    fp_compare_pipe_if.slave  bus
);

    localparam int W     = op_width(WE, WF);
    localparam int MAG_W = mag_width(WE, WF);
    localparam logic [W-1:0] CNAN = W'(canon_nan(WE, WF));

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_ready;
    logic s2_ready;
    logic in_fire;
    logic s2_load;

    assign s2_ready = !s2_valid || bus.out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    // Held low during reset so an operation offered in the reset cycle is
    // never acknowledged.
    assign bus.in_ready = s1_ready && !rst;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign s2_load      = s2_ready && s1_valid;

    // ---------------------------------------------------------------------
    // Stage-1 input decode
    // ---------------------------------------------------------------------
    logic             a_zero, a_norm, a_inf, a_nan, a_sign;
    logic             b_zero, b_norm, b_inf, b_nan, b_sign;
    logic [MAG_W-1:0] a_mag, b_mag;
    cls_t             in_cls_a, in_cls_b;

    fp_classify #(.WE(WE), .WF(WF)) u_cls_a (
        .x       (bus.in_a),
        .is_zero (a_zero),
        .is_norm (a_norm),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .sign    (a_sign),
        .mag     (a_mag)
    );

    fp_classify #(.WE(WE), .WF(WF)) u_cls_b (
        .x       (bus.in_b),
        .is_zero (b_zero),
        .is_norm (b_norm),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .sign    (b_sign),
        .mag     (b_mag)
    );

    assign in_cls_a = '{is_zero: a_zero, is_norm: a_norm, is_inf: a_inf,
                        is_nan: a_nan, sign: a_sign};
    assign in_cls_b = '{is_zero: b_zero, is_norm: b_norm, is_inf: b_inf,
                        is_nan: b_nan, sign: b_sign};

    // ---------------------------------------------------------------------
    // Stage registers
    // ---------------------------------------------------------------------
    logic [W-1:0]     s1_a, s1_b;
    op_e              s1_op;
    logic [TAG_W-1:0] s1_tag;
    cls_t             s1_cls_a, s1_cls_b;
    logic             s1_mag_lt, s1_mag_eq;

    logic             s2_flag;
    logic [W-1:0]     s2_val;
    logic             s2_unord;
    logic [TAG_W-1:0] s2_tag;

    logic             nx_flag;
    logic [W-1:0]     nx_val;
    logic             nx_unord;

    // NOTE: every register here uses non-blocking assignment so all stages
    // sample the pre-edge values; blocking would let S2 see S1's new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_ready) s1_valid <= in_fire;
            if (s2_ready) s2_valid <= s1_valid;
        end
    end

    // NOTE: data registers carry no reset; the valid bits gate everything
    // visible, and the outputs below are masked with s2_valid.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a      <= bus.in_a;
            s1_b      <= bus.in_b;
            s1_op     <= op_e'(bus.in_op);
            s1_tag    <= bus.in_tag;
            s1_cls_a  <= in_cls_a;
            s1_cls_b  <= in_cls_b;
            s1_mag_lt <= (a_mag < b_mag);
            s1_mag_eq <= (a_mag == b_mag);
        end
        if (s2_load) begin
            s2_flag  <= nx_flag;
            s2_val   <= nx_val;
            s2_unord <= nx_unord;
            s2_tag   <= s1_tag;
        end
    end

    // ---------------------------------------------------------------------
    // Stage-2 evaluation
    // ---------------------------------------------------------------------
    logic [2:0] rank_a, rank_b;
    logic       cmp_lt, cmp_eq, cmp_gt;

    assign rank_a = rank_of(s1_cls_a);
    assign rank_b = rank_of(s1_cls_b);

    // NOTE: each always_comb output gets a default first so no path through
    // the case/if tree leaves it unassigned (which would infer a latch).
    always_comb begin
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        if (rank_a != rank_b) begin
            cmp_lt = (rank_a < rank_b);
        end else if (s1_cls_a.is_norm) begin
            // Same-sign normals: larger magnitude is smaller when negative.
            cmp_eq = s1_mag_eq;
            cmp_lt = s1_cls_a.sign ? (!s1_mag_lt && !s1_mag_eq) : s1_mag_lt;
        end else begin
            // Zero/zero or same-sign inf pair; payload bits do not matter.
            cmp_eq = 1'b1;
        end
        cmp_gt = !cmp_lt && !cmp_eq;
    end

    always_comb begin
        nx_unord = s1_cls_a.is_nan || s1_cls_b.is_nan;
        nx_flag  = 1'b0;
        nx_val   = '0;
        unique case (s1_op)
            OP_GT:   nx_flag = !nx_unord && cmp_gt;
            OP_GE:   nx_flag = !nx_unord && !cmp_lt;
            OP_LT:   nx_flag = !nx_unord && cmp_lt;
            OP_LE:   nx_flag = !nx_unord && !cmp_gt;
            OP_EQ:   nx_flag = !nx_unord && cmp_eq;
            OP_NE:   nx_flag = nx_unord || !cmp_eq;
            OP_MIN, OP_MAX: begin
                if (s1_cls_a.is_nan && s1_cls_b.is_nan) begin
                    nx_val = CNAN;
                end else if (s1_cls_a.is_nan) begin
                    nx_flag = 1'b1;
                    nx_val  = s1_b;
                end else if (s1_cls_b.is_nan) begin
                    nx_val = s1_a;
                end else if ((s1_op == OP_MIN) ? cmp_gt : cmp_lt) begin
                    // B strictly wins; ties keep A.
                    nx_flag = 1'b1;
                    nx_val  = s1_b;
                end else begin
                    nx_val = s1_a;
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: masked so an empty stage 2 presents all zeros.
    // ---------------------------------------------------------------------
    assign bus.out_valid = s2_valid;
    assign bus.out_flag  = s2_valid && s2_flag;
    assign bus.out_val   = s2_valid ? s2_val : '0;
    assign bus.out_unord = s2_valid && s2_unord;
    assign bus.out_tag   = s2_valid ? s2_tag : '0;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_compare_pipe
// Directed self-checking bench for fp_compare_pipe. Expected results are
// queued when an operation is accepted and compared as results emerge.
// -----------------------------------------------------------------------------
module tb_fp_compare_pipe;
    import fp_cmp_pkg::*;

    localparam int WE    = 11;
    localparam int WF    = 22;
    localparam int TAG_W = 4;
    localparam int W     = WE + WF + 3;

    typedef struct packed {
        logic             flag;
        logic [W-1:0]     val;
        logic             unord;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk;
    logic rst;

    fp_compare_pipe_if #(.WE(WE), .WF(WF), .TAG_W(TAG_W)) bus ();

    fp_compare_pipe #(.WE(WE), .WF(WF), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t             sb[$];
    int               compared   = 0;
    int               mismatched = 0;
    int               n_sent     = 0;
    int               n_recv     = 0;
    logic [TAG_W-1:0] next_tag   = '0;

    function automatic logic [W-1:0] mk(input logic [1:0] exn, input logic s,
                                        input logic [WE-1:0] e, input logic [WF-1:0] f);
        return {exn, s, e, f};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Called at posedge+#1; leaves in_valid high so sends can run back to back.
    task automatic send(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ef, input logic [W-1:0] ev, input logic eu);
        bit acc;
        int budget;
        acc    = 1'b0;
        budget = 200;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = next_tag;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            budget--;
        end
        #1;
        if (acc) begin
            sb.push_back(exp_t'{flag: ef, val: ev, unord: eu, tag: next_tag});
            n_sent++;
            next_tag++;
        end else begin
            check("send_timeout", 64'(bus.in_ready), 64'd1);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 100) begin
            @(posedge clk);
            b++;
        end
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Result monitor and stall-stability checker, sampling on negedge.
    logic             prev_stall = 1'b0;
    logic             p_flag, p_unord;
    logic [W-1:0]     p_val;
    logic [TAG_W-1:0] p_tag;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_flag",  64'(bus.out_flag),  64'(p_flag));
                check("stall_val",   64'(bus.out_val),   64'(p_val));
                check("stall_unord", 64'(bus.out_unord), 64'(p_unord));
                check("stall_tag",   64'(bus.out_tag),   64'(p_tag));
            end
            if (bus.out_valid && bus.out_ready && !rst) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    n_recv++;
                    check($sformatf("out_tag[exp %0d]",   e.tag), 64'(bus.out_tag),   64'(e.tag));
                    check($sformatf("out_flag[tag %0d]",  e.tag), 64'(bus.out_flag),  64'(e.flag));
                    check($sformatf("out_val[tag %0d]",   e.tag), 64'(bus.out_val),   64'(e.val));
                    check($sformatf("out_unord[tag %0d]", e.tag), 64'(bus.out_unord), 64'(e.unord));
                end
            end
            prev_stall = !rst && bus.out_valid && !bus.out_ready;
            p_flag     = bus.out_flag;
            p_val      = bus.out_val;
            p_unord    = bus.out_unord;
            p_tag      = bus.out_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Operand constants
    logic [W-1:0] one, two, n_one, n_two, p_zero, n_zero;
    logic [W-1:0] nan_a, nan_b, n_inf, n_big, p_inf_a, p_inf_b, cnan;

    initial begin
        one     = mk(EXN_NORM, 1'b0, 11'h3FF, 22'h0);
        two     = mk(EXN_NORM, 1'b0, 11'h400, 22'h0);
        n_one   = mk(EXN_NORM, 1'b1, 11'h3FF, 22'h0);
        n_two   = mk(EXN_NORM, 1'b1, 11'h400, 22'h0);
        p_zero  = mk(EXN_ZERO, 1'b0, 11'h123, 22'h5);
        n_zero  = mk(EXN_ZERO, 1'b1, 11'h000, 22'h0);
        nan_a   = mk(EXN_NAN,  1'b0, 11'h7FF, 22'h1234);
        nan_b   = mk(EXN_NAN,  1'b1, 11'h003, 22'h1);
        n_inf   = mk(EXN_INF,  1'b1, 11'h055, 22'h3);
        n_big   = mk(EXN_NORM, 1'b1, 11'h7E3, 22'h2A5F0);
        p_inf_a = mk(EXN_INF,  1'b0, 11'h000, 22'h0);
        p_inf_b = mk(EXN_INF,  1'b0, 11'h7FF, 22'h3FFFFF);
        cnan    = {2'b11, {(W-2){1'b0}}};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_flag",  64'(bus.out_flag),  64'd0);
        check("rst_out_val",   64'(bus.out_val),   64'd0);
        check("rst_out_unord", 64'(bus.out_unord), 64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;

        // GT 2.0 > 1.0 with exact 2-cycle latency
        send(OP_GT, two, one, 1'b1, '0, 1'b0);
        idle();
        @(negedge clk);
        check("lat_gt_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_gt_cycle2", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Signed zeros (A carries junk exp/frac)
        send(OP_EQ,  p_zero, n_zero, 1'b1, '0, 1'b0);
        send(OP_GT,  p_zero, n_zero, 1'b0, '0, 1'b0);
        send(OP_MIN, p_zero, n_zero, 1'b0, p_zero, 1'b0);
        send(OP_MAX, p_zero, n_zero, 1'b0, p_zero, 1'b0);
        // NaN on A
        send(OP_GT,  nan_a, one, 1'b0, '0, 1'b1);
        send(OP_GE,  nan_a, one, 1'b0, '0, 1'b1);
        send(OP_LT,  nan_a, one, 1'b0, '0, 1'b1);
        send(OP_LE,  nan_a, one, 1'b0, '0, 1'b1);
        send(OP_EQ,  nan_a, one, 1'b0, '0, 1'b1);
        send(OP_NE,  nan_a, one, 1'b1, '0, 1'b1);
        send(OP_MIN, nan_a, one, 1'b1, one, 1'b1);
        send(OP_MAX, nan_a, nan_b, 1'b0, cnan, 1'b1);
        send(OP_MAX, one, nan_b, 1'b0, one, 1'b1);
        // Ordering across signs and classes
        send(OP_LT,  n_two, n_one, 1'b1, '0, 1'b0);
        send(OP_LT,  n_inf, n_big, 1'b1, '0, 1'b0);
        send(OP_GE,  p_inf_a, p_inf_b, 1'b1, '0, 1'b0);
        send(OP_GT,  n_big, n_two, 1'b0, '0, 1'b0);
        send(OP_LE,  n_one, p_zero, 1'b1, '0, 1'b0);
        send(OP_NE,  one, one, 1'b0, '0, 1'b0);
        send(OP_MAX, one, two, 1'b1, two, 1'b0);
        send(OP_MIN, one, two, 1'b0, one, 1'b0);
        idle();
        drain();

        // Backpressure: 8 back-to-back ops, out_ready low for cycles 3-6
        next_tag = '0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (i % 2 == 0) send(OP_GT, two, one, 1'b1, '0, 1'b0);
                    else            send(OP_LT, two, one, 1'b0, '0, 1'b0);
                end
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
                    @(posedge clk);
                end
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight
        bus.out_ready = 1'b0;
        send(OP_EQ, one, one, 1'b1, '0, 1'b0);
        send(OP_GT, two, one, 1'b1, '0, 1'b0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_LT;
        bus.in_tag   = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        sb.delete();
        n_sent = n_sent - 2;
        @(negedge clk);
        check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst2_out_flag",  64'(bus.out_flag),  64'd0);
        check("rst2_out_val",   64'(bus.out_val),   64'd0);
        check("rst2_out_unord", 64'(bus.out_unord), 64'd0);
        check("rst2_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst2_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(OP_MAX, n_two, one, 1'b1, one, 1'b0);
        idle();
        @(negedge clk);
        check("lat_rst_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_rst_cycle2", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();
        repeat (3) @(posedge clk);
        check("total_results", 64'(n_recv), 64'(n_sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, pipelined floating-point comparator/selector for the Ray-AABB datapath; next generation of the single-flag greater-than unit.
- Compares two FloPoCo-format operands directly, with no subtractor, and handles every exception class (zero/normal/inf/NaN).
- Supports 8 runtime-selectable modes, including MIN/MAX selection for the slab tmin/tmax reductions.
- Provides a valid/ready handshake with backpressure and a tag passthrough, so results can be re-associated with rays.

Parameters:
- WE, 11, exponent width.
- WF, 22, fraction width.
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- Derived, not overridable: W = WE+WF+3, the operand width (36 by default).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. Synchronous and active-high, sampled only on the rising edge of clk.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  3  mode (see Behaviour).
- in_a  in  W  operand A, FloPoCo format.
- in_b  in  W  operand B, FloPoCo format.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_flag  out  1  predicate result; for MIN/MAX, 1 = B selected.
- out_val  out  W  selected operand for MIN/MAX; 0 for predicate modes.
- out_unord  out  1  at least one operand is NaN.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Operand layout: [W-1:W-2] exn (00 zero, 01 normal, 10 inf, 11 NaN); [W-3] sign; [W-4:WF] exponent; [WF-1:0] fraction.
- Modes: 000 GT, 001 GE, 010 LT, 011 LE, 100 EQ, 101 NE, 110 MIN, 111 MAX. Predicates evaluate "A op B".
- Ordering:
  - -inf < -normal < zero < +normal < +inf.
  - +0 and -0 compare equal, regardless of the exponent/fraction bits carried with exn=00.
  - Normals of the same sign are ordered by the unsigned {exp,frac}; the ordering is reversed when both are negative.
  - inf vs inf of the same sign is equal.
  - Exponent/fraction bits of inf operands are ignored.
- NaN handling:
  - Any NaN operand sets out_unord=1.
  - All predicates return 0 except NE, which returns 1.
  - MIN/MAX with exactly one NaN returns the other operand unmodified.
  - MIN/MAX with both NaN returns canonical NaN: exn=11, all other bits 0, flag=0.
- MIN/MAX on equal operands (including ±0 pairs) returns A, with flag=0.
- Pipeline: 2 register stages.
  - S1 registers the operands, op and tag, the exn classes, and the magnitude lt/eq of {exp,frac}.
  - S2 registers the final flag, val, unord and tag.
  - Latency is exactly 2 cycles from the in_valid&&in_ready cycle to out_valid when there is no stall.
- Throughput is 1 operation/cycle.
- Handshake:
  - A stage loads when it is empty or its contents advance in the same cycle.
  - in_ready = !s1_full || (s1 advancing). It may depend combinationally on out_ready.
  - While out_valid=1 && out_ready=0, all out_* outputs hold stable.
  - No operation is dropped or duplicated.
- Bubbles: empty stages collapse. A new input enters S1 in the same cycle that S1's content moves to an empty S2.
- Reset (rst=1 at an edge):
  - Both stage valids clear. out_valid=0, out_flag=0, out_val=0, out_unord=0, out_tag=0.
  - in_ready=1 in the cycle following reset.
  - Operations in flight are discarded. An input presented in the reset cycle is not accepted.
- X-safety: data registers update only on load. Valid bits are the only state that must reset.

Decomposition:
- Package fp_cmp_pkg holds:
  - op code constants (OP_GT..OP_MAX);
  - exn code constants (EXN_ZERO, EXN_NORM, EXN_INF, EXN_NAN);
  - field-index functions of WE/WF;
  - the canonical-NaN constant function.
- Sub-module fp_classify: combinational decode of one operand into is_zero/is_norm/is_inf/is_nan/sign/mag. It is instantiated twice in S1.

Test Plan:
- GT on A=2.0 (exn=01, s=0, exp=0x400, f=0) and B=1.0 (exp=0x3FF, f=0), op=000, out_ready=1:
  - out_valid exactly 2 cycles after acceptance, flag=1, unord=0, val=0.
- Signed zero, A=+0 and B=-0:
  - EQ → flag=1; GT → flag=0.
  - MIN → val=A (+0), flag=0.
  - MAX → val=A, flag=0.
- NaN handling, A=NaN (exn=11) and B=1.0:
  - GT/GE/LT/LE/EQ → flag=0, unord=1; NE → flag=1.
  - MIN → val=B, flag=1.
  - A=B=NaN with MAX → val=canonical NaN.
- Negative ordering:
  - A=-2.0, B=-1.0, LT → flag=1.
  - A=-inf, B=-1.0e300-class normal, LT → flag=1.
  - A=+inf, B=+inf, GE → flag=1.
- Backpressure, 8 back-to-back ops with tags 0..7, out_ready low for cycles 3-6:
  - Results emerge in tag order 0..7, none lost or duplicated.
  - Outputs stay stable while stalled.
  - in_ready=0 while both stages are full and stalled.
- Reset mid-stream: assert rst with 2 ops in flight:
  - Next cycle out_valid=0 and all outputs are 0.
  - A new op is accepted after reset and produces its result exactly 2 cycles later.
